// File: rtl/frame_check.sv
// Serial frame checker: start / DATA_WIDTH data bits LSB first / optional parity / STOP_BITS stop bits.
// Latency: outputs registered; frame_done and its error flags appear 1 cycle after the final stop strobe.
// Backpressure: none; the sampler paces the FSM via bit_valid, and cycles without a strobe hold all state.
// Optional saturating error counter enabled by defining FRAME_CHECK_ERR_CNT_EN; otherwise err_count is 0.
module frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  sampled_bit,
   input  logic                  bit_valid,
   input  logic                  par_en,
   input  logic                  par_type,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done,
   output logic                  start_error,
   output logic                  parity_error,
   output logic                  stop_error,
   output logic                  busy,
   output logic [7:0]            err_count
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_type_q, par_type_d;
   logic                  par_err_q, par_err_d;
   logic                  stop_err_q, stop_err_d;
   logic                  done_q, done_d;
   logic                  start_out_q, start_out_d;
   logic                  par_out_q, par_out_d;
   logic                  stop_out_q, stop_out_d;
   logic                  busy_q, busy_d;
   logic                  stop_hit;

   // Next-state logic: the FSM only moves on bit_valid strobes; pulse outputs default low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      data_d      = data_q;
      par_en_d    = par_en_q;
      par_type_d  = par_type_q;
      par_err_d   = par_err_q;
      stop_err_d  = stop_err_q;
      done_d      = 1'b0;
      start_out_d = 1'b0;
      par_out_d   = 1'b0;
      stop_out_d  = 1'b0;
      stop_hit    = stop_err_q | ~sampled_bit;
      if (bit_valid) begin
         case (state_q)
            IDLE: begin
               if (!sampled_bit) begin
                  // Frame options are frozen here so mid-frame changes cannot corrupt the check.
                  state_d    = DATA;
                  cnt_d      = '0;
                  par_en_d   = par_en;
                  par_type_d = par_type;
                  par_err_d  = 1'b0;
                  stop_err_d = 1'b0;
               end else begin
                  start_out_d = 1'b1;
               end
            end
            DATA: begin
               shadow_d = {sampled_bit, shadow_q[DATA_WIDTH-1:1]};
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  cnt_d   = '0;
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PARITY: begin
               // Even parity expects the XOR of the data; odd expects its inverse.
               par_err_d = sampled_bit != ((^shadow_q) ^ par_type_q);
               cnt_d     = '0;
               state_d   = STOP;
            end
            STOP: begin
               stop_err_d = stop_hit;
               if (cnt_q == CW'(STOP_BITS - 1)) begin
                  state_d    = IDLE;
                  cnt_d      = '0;
                  done_d     = 1'b1;
                  par_out_d  = par_err_q;
                  stop_out_d = stop_hit;
                  if (!par_err_q && !stop_hit) begin
                     data_d = shadow_q;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset wins over any strobe in the same cycle.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         par_en_q    <= 1'b0;
         par_type_q  <= 1'b0;
         par_err_q   <= 1'b0;
         stop_err_q  <= 1'b0;
         done_q      <= 1'b0;
         start_out_q <= 1'b0;
         par_out_q   <= 1'b0;
         stop_out_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         par_en_q    <= par_en_d;
         par_type_q  <= par_type_d;
         par_err_q   <= par_err_d;
         stop_err_q  <= stop_err_d;
         done_q      <= done_d;
         start_out_q <= start_out_d;
         par_out_q   <= par_out_d;
         stop_out_q  <= stop_out_d;
         busy_q      <= busy_d;
      end
   end

   assign data_out     = data_q;
   assign frame_done   = done_q;
   assign start_error  = start_out_q;
   assign parity_error = par_out_q;
   assign stop_error   = stop_out_q;
   assign busy         = busy_q;

`ifdef FRAME_CHECK_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // One increment per cycle with any error pulse, saturating at 255.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((start_out_q || par_out_q || stop_out_q) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Error counter register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'd0;
`endif

endmodule

// File: doc/frame_check.md
FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset is synchronous and active-high.
REQ-005 sampled_bit  input  1  serial bit value from the sampler.
REQ-006 bit_valid  input  1  one-cycle strobe; sampled_bit is valid this cycle.
REQ-007 par_en  input  1  1 = frame carries a parity bit after the data bits.
REQ-008 par_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 data_out  output  DATA_WIDTH  last error-free received word.
REQ-010 frame_done  output  1  one-cycle pulse at the end of every frame that passed the start check.
REQ-011 start_error  output  1  one-cycle pulse; start bit sampled as 1.
REQ-012 parity_error  output  1  one-cycle pulse with frame_done; parity mismatch.
REQ-013 stop_error  output  1  one-cycle pulse with frame_done; any stop bit sampled as 0.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_count  output  8  saturating error counter (present only per REQ-032).

Function
REQ-016 FSM states: IDLE, DATA, PARITY, STOP; state advances only in cycles with bit_valid=1.
REQ-017 IDLE: bit_valid with sampled_bit=0 -> DATA; with sampled_bit=1 -> start_error=1 next cycle, remain IDLE.
REQ-018 par_en and par_type are latched on the start-bit strobe; changes mid-frame have no effect on the current frame.
REQ-019 DATA: bits shifted in LSB first into a shadow register; after DATA_WIDTH strobes -> PARITY if latched par_en=1, else STOP.
REQ-020 PARITY: one strobe; expected bit = XOR of data bits (even) or its inverse (odd); mismatch is recorded; -> STOP.
REQ-021 STOP: STOP_BITS strobes; every stop bit is checked; a 0 stop bit records a stop error but the FSM still consumes all STOP_BITS strobes.
REQ-022 On the final stop strobe -> IDLE; on the next cycle frame_done=1, parity_error and stop_error reflect the recorded errors.
REQ-023 data_out is updated with the shadow register in the frame_done cycle only when neither parity_error nor stop_error is asserted; otherwise it holds.
REQ-024 All outputs are registered; latency from the last-bit strobe to frame_done is exactly 1 cycle.
REQ-025 Bit/state counter width is clog2(DATA_WIDTH+1); counters clear on every state entry.
REQ-026 Cycles with bit_valid=0 hold all state; pulses (frame_done, *_error) last exactly one cycle.
REQ-027 A start-bit strobe in the same cycle frame_done is asserted is accepted normally (back-to-back frames).

Reset
REQ-028 Reset=1 at a rising edge forces state IDLE, counters 0, data_out 0, all pulse outputs 0, busy 0, err_count 0.
REQ-029 Reset has priority over bit_valid; a strobe in a reset cycle is discarded.
REQ-030 Reset mid-frame aborts the frame with no frame_done and no error pulse.

Configuration
REQ-031 Macro FRAME_CHECK_ERR_CNT_EN controls the error counter.
REQ-032 Defined: err_count increments by 1 per cycle in which any of start_error, parity_error, stop_error is 1 (one increment per cycle even if several are set), saturating at 255.
REQ-033 Undefined: counter logic absent and err_count is tied to 0.

Verification
REQ-034 DATA_WIDTH=8, 8N1, bits 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop) -> frame_done, data_out=0xA5, no errors.
REQ-035 par_en=1 par_type=0, data 0x07, parity bit 0 -> parity_error=1 with frame_done, data_out unchanged, err_count=1.
REQ-036 Start bit 1 -> start_error pulse one cycle later, busy stays 0, no frame_done.
REQ-037 STOP_BITS=2, data 0x3C, stop bits 1,0 -> stop_error with frame_done only after the 2nd stop strobe, data_out unchanged.
REQ-038 Reset asserted after 4 data strobes, then clean frame 0x5A -> no pulse for aborted frame, data_out=0x5A.
REQ-039 With FRAME_CHECK_ERR_CNT_EN, 260 start-error events -> err_count=255 and holds.
